// File: rtl/wb_stream_writer_pkg.sv
// Shared types for the stream-to-Wishbone writer: FSM states and bus response decode.
package wb_stream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    BACKOFF = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_ACK  = 2'd1,
    RSP_ERR  = 2'd2,
    RSP_RTY  = 2'd3
  } rsp_e;

  // ack beats err beats rty when a device asserts several at once.
  function automatic rsp_e decode_rsp(input logic ack, input logic err, input logic rty);
    rsp_e rsp;
    if (ack)      rsp = RSP_ACK;
    else if (err) rsp = RSP_ERR;
    else if (rty) rsp = RSP_RTY;
    else          rsp = RSP_NONE;
    return rsp;
  endfunction

endpackage

// File: rtl/wb_stream_writer_if.sv
// Wishbone classic bus bundle; controller drives the cycle, device answers it.
interface wishbone_classic #(
  parameter int DAT_WIDTH = 8
);
  logic                 cyc_o;
  logic                 stb_o;
  logic                 we_o;
  logic [DAT_WIDTH-1:0] dat_o;
  logic [DAT_WIDTH-1:0] dat_i;
  logic                 ack_i;
  logic                 err_i;
  logic                 rty_i;

  modport controller (
    output cyc_o, stb_o, we_o, dat_o,
    input  dat_i, ack_i, err_i, rty_i
  );

  modport device (
    input  cyc_o, stb_o, we_o, dat_o,
    output dat_i, ack_i, err_i, rty_i
  );
endinterface

// File: rtl/wb_stream_writer_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; sticks at all-ones.
module wb_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (inc_i && !(&count_q)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/wb_stream_writer.sv
// Turns each accepted stream beat into one Wishbone classic write, with bounded rty retries.
// Optional response timeout is enabled by defining WB_STREAM_WRITER_TIMEOUT_EN.
module wb_stream_writer
  import wb_stream_pkg::*;
#(
  parameter int DAT_WIDTH = 8,
  parameter int MAX_RETRY = 3,
  parameter int RETRY_GAP = 2,
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [DAT_WIDTH-1:0] s_data_i,
  wishbone_classic.controller  wb,
  output logic                 busy_o,
  output logic                 err_pulse_o,
  output logic [CNT_WIDTH-1:0] drop_count_o
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int GW = (RETRY_GAP < 2) ? 1 : $clog2(RETRY_GAP);

  state_e               state_q, state_d;
  logic [DAT_WIDTH-1:0] hold_q, hold_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 cyc_q, cyc_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 err_pulse_q;
  logic                 drop;
  rsp_e                 rsp;

`ifdef WB_STREAM_WRITER_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [TW-1:0] timer_q, timer_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      retry_q     <= '0;
      gap_q       <= '0;
      cyc_q       <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      retry_q     <= retry_d;
      gap_q       <= gap_d;
      cyc_q       <= cyc_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      err_pulse_q <= drop;
    end
  end

`ifdef WB_STREAM_WRITER_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) timer_q <= '0;
    else         timer_q <= timer_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    retry_d = retry_q;
    gap_d   = gap_q;
    drop    = 1'b0;
`ifdef WB_STREAM_WRITER_TIMEOUT_EN
    timer_d = timer_q;
`endif
    // Responses are only looked at in ACTIVE, i.e. while cyc_o is high.
    rsp = decode_rsp(wb.ack_i, wb.err_i, wb.rty_i);

    unique case (state_q)
      IDLE: begin
        if (s_valid_i && ready_q) begin
          hold_d  = s_data_i;
          retry_d = '0;
          state_d = ACTIVE;
`ifdef WB_STREAM_WRITER_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      ACTIVE: begin
        unique case (rsp)
          RSP_ACK: state_d = IDLE;
          RSP_ERR: begin
            state_d = IDLE;
            drop    = 1'b1;
          end
          RSP_RTY: begin
            if (retry_q == RW'(MAX_RETRY)) begin
              state_d = IDLE;
              drop    = 1'b1;
            end else begin
              retry_d = retry_q + 1'b1;
              gap_d   = GW'(RETRY_GAP - 1);
              state_d = BACKOFF;
            end
          end
          default: begin
`ifdef WB_STREAM_WRITER_TIMEOUT_EN
            // The count is the number of silent ACTIVE cycles already completed.
            if (timer_q == TW'(TIMEOUT - 1)) begin
              state_d = IDLE;
              drop    = 1'b1;
            end else begin
              timer_d = timer_q + 1'b1;
            end
`endif
          end
        endcase
      end
      BACKOFF: begin
        if (gap_q == '0) begin
          state_d = ACTIVE;
`ifdef WB_STREAM_WRITER_TIMEOUT_EN
          timer_d = '0;
`endif
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    cyc_d   = (state_d == ACTIVE);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  wb_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_drop_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (drop),
    .count_o (drop_count_o)
  );

  assign wb.cyc_o    = cyc_q;
  assign wb.stb_o    = cyc_q;
  assign wb.we_o     = cyc_q;
  assign wb.dat_o    = hold_q;
  assign s_ready_o   = ready_q;
  assign busy_o      = busy_q;
  assign err_pulse_o = err_pulse_q;

endmodule

// File: tb/tb_wb_stream_writer.sv
// Directed bench for wb_stream_writer: registered/combinational ack, retries, drops, saturation, reset, timeout.
module tb_wb_stream_writer;

  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int GAP  = 2;
  localparam int MAXR = 3;
  localparam int TOUT = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [DW-1:0] s_data_i = '0;
  logic          busy_o;
  logic          err_pulse_o;
  logic [CW-1:0] drop_count_o;

  logic ack_drv = 1'b0, err_drv = 1'b0, rty_drv = 1'b0, comb_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  wishbone_classic #(.DAT_WIDTH(DW)) wb ();

  assign wb.ack_i = ack_drv | (comb_ack & wb.cyc_o);
  assign wb.err_i = err_drv;
  assign wb.rty_i = rty_drv;
  assign wb.dat_i = '0;

  wb_stream_writer #(
    .DAT_WIDTH (DW),
    .MAX_RETRY (MAXR),
    .RETRY_GAP (GAP),
    .TIMEOUT   (TOUT),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .s_data_i     (s_data_i),
    .wb           (wb),
    .busy_o       (busy_o),
    .err_pulse_o  (err_pulse_o),
    .drop_count_o (drop_count_o)
  );

  // Bus monitor: cycle numbers of handshakes, cyc_o high cycles, rising edges, error pulses.
  int   cycle_n = 0, hs_last = 0, hs_prev = 0;
  int   cyc_hi_n = 0, cyc_rise_n = 0, err_pulse_n = 0;
  logic cyc_prev = 1'b0;
  always @(posedge clk_i) begin
    cycle_n++;
    if (s_valid_i && s_ready_o) begin
      hs_prev = hs_last;
      hs_last = cycle_n;
    end
    if (wb.cyc_o) cyc_hi_n++;
    if (wb.cyc_o && !cyc_prev) cyc_rise_n++;
    if (err_pulse_o) err_pulse_n++;
    cyc_prev = wb.cyc_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    s_valid_i = 1'b1;
    s_data_i  = d;
    tick();
    s_valid_i = 1'b0;
  endtask

  task automatic drive_rsp(input logic a, input logic e, input logic r);
    ack_drv = a;
    err_drv = e;
    rty_drv = r;
    tick();
    ack_drv = 1'b0;
    err_drv = 1'b0;
    rty_drv = 1'b0;
  endtask

  task automatic check_gap(input string tag);
    for (int g = 0; g < GAP; g++) begin
      check_eq(tag, {31'd0, wb.cyc_o}, 32'd0);
      tick();
    end
  endtask

  initial begin
    int base_hi, base_rise, base_err;

    // Reset values
    tick();
    check_eq("rst_cyc", {31'd0, wb.cyc_o}, 32'd0);
    check_eq("rst_stb_we", {30'd0, wb.stb_o, wb.we_o}, 32'd0);
    check_eq("rst_dat", {24'd0, wb.dat_o}, 32'd0);
    check_eq("rst_ready", {31'd0, s_ready_o}, 32'd0);
    check_eq("rst_busy_err", {30'd0, busy_o, err_pulse_o}, 32'd0);
    check_eq("rst_drop", {24'd0, drop_count_o}, 32'd0);
    rst_ni = 1'b1;
    tick();
    check_eq("ready_after_rst", {31'd0, s_ready_o}, 32'd1);

    // Registered-ack device, 0x11 then 0x22 with valid held
    base_hi = cyc_hi_n;
    s_valid_i = 1'b1;
    s_data_i  = 8'h11;
    tick();
    check_eq("t1_cyc", {31'd0, wb.cyc_o}, 32'd1);
    check_eq("t1_dat0", {24'd0, wb.dat_o}, 32'h11);
    check_eq("t1_ready_low", {31'd0, s_ready_o}, 32'd0);
    check_eq("t1_busy", {31'd0, busy_o}, 32'd1);
    check_eq("t1_stb_we", {30'd0, wb.stb_o, wb.we_o}, 32'd3);
    s_data_i = 8'h22;
    tick();
    check_eq("t1_wait_cyc", {31'd0, wb.cyc_o}, 32'd1);
    drive_rsp(1'b1, 1'b0, 1'b0);
    check_eq("t1_ack_cyc", {31'd0, wb.cyc_o}, 32'd0);
    check_eq("t1_ack_ready", {31'd0, s_ready_o}, 32'd1);
    tick();
    s_valid_i = 1'b0;
    check_eq("t1_dat1", {24'd0, wb.dat_o}, 32'h22);
    check_eq("t1_beat_period", hs_last - hs_prev, 32'd3);
    tick();
    drive_rsp(1'b1, 1'b0, 1'b0);
    check_eq("t1_done_cyc", {31'd0, wb.cyc_o}, 32'd0);
    check_eq("t1_drop", {24'd0, drop_count_o}, 32'd0);
    check_eq("t1_cyc_hi", cyc_hi_n - base_hi, 32'd4);

    // Combinational ack in the same cycle as cyc_o
    tick();
    base_hi  = cyc_hi_n;
    comb_ack = 1'b1;
    s_valid_i = 1'b1;
    s_data_i  = 8'h33;
    tick();
    check_eq("t2_dat0", {24'd0, wb.dat_o}, 32'h33);
    s_data_i = 8'h44;
    tick();
    check_eq("t2_cyc_low", {31'd0, wb.cyc_o}, 32'd0);
    check_eq("t2_ready", {31'd0, s_ready_o}, 32'd1);
    tick();
    s_valid_i = 1'b0;
    check_eq("t2_dat1", {24'd0, wb.dat_o}, 32'h44);
    check_eq("t2_beat_period", hs_last - hs_prev, 32'd2);
    tick();
    comb_ack = 1'b0;
    check_eq("t2_idle", {31'd0, s_ready_o}, 32'd1);
    tick();
    check_eq("t2_cyc_hi", cyc_hi_n - base_hi, 32'd2);

    // rty twice then ack
    base_rise = cyc_rise_n;
    base_err  = err_pulse_n;
    send_beat(8'h5A);
    for (int k = 0; k < 2; k++) begin
      check_eq("t3_cyc", {31'd0, wb.cyc_o}, 32'd1);
      check_eq("t3_dat", {24'd0, wb.dat_o}, 32'h5A);
      drive_rsp(1'b0, 1'b0, 1'b1);
      check_gap("t3_gap");
    end
    check_eq("t3_cyc_last", {31'd0, wb.cyc_o}, 32'd1);
    check_eq("t3_dat_last", {24'd0, wb.dat_o}, 32'h5A);
    drive_rsp(1'b1, 1'b0, 1'b0);
    check_eq("t3_ready", {31'd0, s_ready_o}, 32'd1);
    tick();
    check_eq("t3_pulses", cyc_rise_n - base_rise, 32'd3);
    check_eq("t3_no_err", err_pulse_n - base_err, 32'd0);
    check_eq("t3_drop", {24'd0, drop_count_o}, 32'd0);

    // rty four times with MAX_RETRY=3 drops the beat
    send_beat(8'h77);
    for (int k = 0; k < MAXR; k++) begin
      check_eq("t4_dat", {24'd0, wb.dat_o}, 32'h77);
      drive_rsp(1'b0, 1'b0, 1'b1);
      check_gap("t4_gap");
    end
    check_eq("t4_cyc_last", {31'd0, wb.cyc_o}, 32'd1);
    drive_rsp(1'b0, 1'b0, 1'b1);
    check_eq("t4_err_pulse", {31'd0, err_pulse_o}, 32'd1);
    check_eq("t4_drop", {24'd0, drop_count_o}, 32'd1);
    check_eq("t4_cyc", {31'd0, wb.cyc_o}, 32'd0);
    check_eq("t4_idle", {30'd0, s_ready_o, busy_o}, 32'd2);
    tick();
    check_eq("t4_pulse_end", {31'd0, err_pulse_o}, 32'd0);

    // ack and err together count as success
    send_beat(8'hA5);
    drive_rsp(1'b1, 1'b1, 1'b0);
    check_eq("t5_ackerr_pulse", {31'd0, err_pulse_o}, 32'd0);
    check_eq("t5_ackerr_drop", {24'd0, drop_count_o}, 32'd1);

    // Saturation: 254 more errs reach 0xFF, 2 further stay there
    base_err = err_pulse_n;
    for (int i = 0; i < 254; i++) begin
      send_beat(DW'(i));
      drive_rsp(1'b0, 1'b1, 1'b0);
    end
    check_eq("t5_drop_ff", {24'd0, drop_count_o}, 32'hFF);
    for (int i = 0; i < 2; i++) begin
      send_beat(DW'(i));
      drive_rsp(1'b0, 1'b1, 1'b0);
    end
    check_eq("t5_drop_sat", {24'd0, drop_count_o}, 32'hFF);
    tick();
    check_eq("t5_err_pulses", err_pulse_n - base_err, 32'd256);

    // Reset mid-ACTIVE takes effect without a clock edge
    send_beat(8'h99);
    check_eq("t6_cyc_pre", {31'd0, wb.cyc_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("t6_cyc_async", {31'd0, wb.cyc_o}, 32'd0);
    check_eq("t6_dat", {24'd0, wb.dat_o}, 32'd0);
    check_eq("t6_drop", {24'd0, drop_count_o}, 32'd0);
    check_eq("t6_rdy_busy", {30'd0, s_ready_o, busy_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    check_eq("t6_ready_back", {31'd0, s_ready_o}, 32'd1);

`ifdef WB_STREAM_WRITER_TIMEOUT_EN
    // Silent device: cyc_o high exactly TIMEOUT cycles, then dropped like err
    send_beat(8'hC3);
    for (int k = 0; k < TOUT; k++) begin
      check_eq("t7_cyc_hold", {31'd0, wb.cyc_o}, 32'd1);
      tick();
    end
    check_eq("t7_cyc_drop", {31'd0, wb.cyc_o}, 32'd0);
    check_eq("t7_err_pulse", {31'd0, err_pulse_o}, 32'd1);
    check_eq("t7_drop", {24'd0, drop_count_o}, 32'd1);
`else
    // Silent device: the block keeps waiting with stable bus signals
    send_beat(8'hC3);
    for (int k = 0; k < 10; k++) begin
      check_eq("t7_cyc_hold", {31'd0, wb.cyc_o}, 32'd1);
      check_eq("t7_dat_hold", {24'd0, wb.dat_o}, 32'hC3);
      tick();
    end
    drive_rsp(1'b1, 1'b0, 1'b0);
    check_eq("t7_done", {31'd0, s_ready_o}, 32'd1);
    check_eq("t7_drop", {24'd0, drop_count_o}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
